// File: rtl/conv_encoder_param.sv
// Parametrised rate-1/N feed-forward convolutional encoder with valid/ready
// handshakes on both sides and optional zero-tail frame termination.
// Generator i lives in GENS[i*K +: K]; its bit K-1 taps the current input
// and bit 0 taps the oldest stored bit.
module conv_encoder_param #(
  parameter int              K       = 3,
  parameter int              N       = 2,
  parameter logic [N*K-1:0]  GENS    = 6'b101111,
  parameter int              TAIL_EN = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_bit,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_sym,
  output logic         out_last,
  output logic         busy
);

  // Tail counter must hold K-1.
  localparam int             TCW      = $clog2(K);
  localparam logic [TCW-1:0] TAIL_LEN = TCW'(K - 1);
  localparam bit             USE_TAIL = (TAIL_EN != 0) && (K > 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    TAIL
  } state_t;

  state_t         state;
  state_t         state_n;
  logic [K-2:0]   sr;
  logic [K-2:0]   sr_n;
  logic [TCW-1:0] tc;
  logic [TCW-1:0] tc_n;
  logic [N-1:0]   sym_n;
  logic           valid_n;
  logic           last_n;

  logic           stage_free;
  logic           accept;
  logic           u;
  logic [K-1:0]   window;
  logic [N-1:0]   enc;

  // The output register can take a new symbol when it is empty or being drained.
  assign stage_free = !out_valid || out_ready;
  assign in_ready   = (state != TAIL) && stage_free;
  assign accept     = in_valid && in_ready;

  // During the tail the encoder is fed zeros instead of the input bit.
  assign u      = (state == TAIL) ? 1'b0 : in_bit;
  assign window = {u, sr};
  assign busy   = (state != IDLE) || out_valid;

  // Parity of each generator over the current bit and the stored history.
  always_comb begin
    enc = '0;
    for (int i = 0; i < N; i++) begin
      enc[i] = ^(GENS[i*K +: K] & window);
    end
  end

  // Next-state and next-output logic: accept data, run the zero tail, drain output.
  always_comb begin
    state_n = state;
    sr_n    = sr;
    tc_n    = tc;
    sym_n   = out_sym;
    valid_n = out_valid;
    last_n  = out_last;

    if (stage_free) begin
      valid_n = 1'b0;
      last_n  = 1'b0;
    end

    case (state)
      IDLE, DATA: begin
        if (accept) begin
          sym_n   = enc;
          valid_n = 1'b1;
          last_n  = 1'b0;
          sr_n    = window[K-1:1];
          if (in_last) begin
            if (USE_TAIL) begin
              state_n = TAIL;
              tc_n    = TAIL_LEN;
            end else begin
              last_n  = 1'b1;
              sr_n    = '0;
              state_n = IDLE;
            end
          end else begin
            state_n = DATA;
          end
        end
      end
      TAIL: begin
        if (stage_free) begin
          sym_n   = enc;
          valid_n = 1'b1;
          last_n  = 1'b0;
          sr_n    = window[K-1:1];
          tc_n    = tc - TCW'(1);
          if (tc == TCW'(1)) begin
            last_n  = 1'b1;
            sr_n    = '0;
            state_n = IDLE;
          end
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State, shift register, tail counter and output stage registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      sr        <= '0;
      tc        <= '0;
      out_sym   <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      state     <= state_n;
      sr        <= sr_n;
      tc        <= tc_n;
      out_sym   <= sym_n;
      out_valid <= valid_n;
      out_last  <= last_n;
    end
  end

endmodule

// File: tb/tb_conv_encoder_param.sv
// Self-checking bench for conv_encoder_param. Three instances cover K=3 with
// tail, K=3 without tail and K=7 (133/171 octal) with tail. Expected symbols
// come from a frame-level model that keeps the plain bit history of the frame.
module tb_conv_encoder_param;

  logic       clock = 1'b0;
  logic       reset;
  logic       in_valid  [3];
  logic       in_ready  [3];
  logic       in_bit    [3];
  logic       in_last   [3];
  logic       out_valid [3];
  logic       out_ready [3];
  logic [1:0] out_sym   [3];
  logic       out_last  [3];
  logic       busy      [3];

  typedef struct packed {
    logic [1:0] sym;
    logic       last;
  } exp_t;

  exp_t        expq[$];
  bit          frame_bits[$];
  int          n_checks  = 0;
  int          n_fail    = 0;
  int          sel       = 0;
  int          rmode     = 0;
  int          sym_count = 0;
  int          k_of[3]    = '{3, 3, 7};
  int          tail_of[3] = '{1, 0, 1};
  logic [13:0] gens_of[3] = '{14'b101111, 14'b101111, {7'o133, 7'o171}};

  always #5 clock = ~clock;

  conv_encoder_param #(.K(3), .N(2), .GENS(6'b101111), .TAIL_EN(1)) dut_k3 (
    .clock(clock), .reset(reset),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_bit(in_bit[0]), .in_last(in_last[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_sym(out_sym[0]),
    .out_last(out_last[0]), .busy(busy[0])
  );

  conv_encoder_param #(.K(3), .N(2), .GENS(6'b101111), .TAIL_EN(0)) dut_notail (
    .clock(clock), .reset(reset),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_bit(in_bit[1]), .in_last(in_last[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_sym(out_sym[1]),
    .out_last(out_last[1]), .busy(busy[1])
  );

  conv_encoder_param #(.K(7), .N(2), .GENS({7'o133, 7'o171}), .TAIL_EN(1)) dut_k7 (
    .clock(clock), .reset(reset),
    .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_bit(in_bit[2]), .in_last(in_last[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_sym(out_sym[2]),
    .out_last(out_last[2]), .busy(busy[2])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected symbols of the current frame: hist[j] is the bit j steps back,
  // and generator bit K-1-j multiplies it.
  function automatic void model_frame(input int s);
    int   k;
    int   total;
    bit   hist[$];
    bit   b;
    bit   p;
    exp_t e;
    k     = k_of[s];
    total = frame_bits.size() + tail_of[s] * (k - 1);
    for (int t = 0; t < total; t++) begin
      b = (t < frame_bits.size()) ? frame_bits[t] : 1'b0;
      hist.push_front(b);
      e = '0;
      for (int i = 0; i < 2; i++) begin
        p = 1'b0;
        for (int j = 0; j < k; j++) begin
          if (j < hist.size()) p = p ^ (gens_of[s][i*k + (k-1-j)] & hist[j]);
        end
        e.sym[i] = p;
      end
      e.last = (t == total - 1);
      expq.push_back(e);
    end
  endfunction

  // Downstream ready pattern: always ready, strict 1010 toggle, or random stalls.
  initial begin : ready_driver
    bit tog;
    tog = 1'b0;
    for (int i = 0; i < 3; i++) out_ready[i] = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      for (int i = 0; i < 3; i++) out_ready[i] = 1'b1;
      tog = ~tog;
      case (rmode)
        1:       out_ready[sel] = tog;
        2:       out_ready[sel] = ($urandom_range(0, 3) != 0);
        default: out_ready[sel] = 1'b1;
      endcase
    end
  end

  // Output monitor: compares every handshaken symbol with the model and
  // checks that a stalled symbol stays put.
  initial begin : monitor
    bit         stalled;
    logic [1:0] held_sym;
    logic       held_last;
    exp_t       e;
    stalled = 1'b0;
    forever begin
      @(negedge clock);
      if (reset) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          chk("hold_valid", out_valid[sel], 1'b1);
          chk("hold_sym", out_sym[sel], held_sym);
          chk("hold_last", out_last[sel], held_last);
        end
        if (out_valid[sel] && out_ready[sel]) begin
          n_checks++;
          assert (expq.size() > 0) else begin
            n_fail++;
            $error("[TB] FAIL extra_symbol: observed sym %b last %b, expected no symbol",
                   out_sym[sel], out_last[sel]);
          end
          if (expq.size() > 0) begin
            e = expq.pop_front();
            chk("out_sym", out_sym[sel], e.sym);
            chk("out_last", out_last[sel], e.last);
            sym_count++;
          end
        end
        stalled   = out_valid[sel] && !out_ready[sel];
        held_sym  = out_sym[sel];
        held_last = out_last[sel];
      end
    end
  end

  task automatic send_bit(input int s, input bit b, input bit last);
    int guard;
    guard       = 0;
    in_valid[s] = 1'b1;
    in_bit[s]   = b;
    in_last[s]  = last;
    @(negedge clock);
    while (!in_ready[s] && guard < 200) begin
      @(negedge clock);
      guard++;
    end
    chk("accept_in_time", in_ready[s], 1'b1);
    @(posedge clock);
    #1;
    in_valid[s] = 1'b0;
    in_bit[s]   = 1'($urandom);
    in_last[s]  = 1'($urandom);
  endtask

  task automatic send_frame(input int s, input bit gaps);
    sel       = s;
    sym_count = 0;
    model_frame(s);
    for (int t = 0; t < frame_bits.size(); t++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        @(posedge clock);
        #1;
      end
      send_bit(s, frame_bits[t], t == frame_bits.size() - 1);
    end
  endtask

  // Drain the frame; with a tail, in_ready stays low until the final symbol shows.
  task automatic drain(input int s);
    int guard;
    guard = 0;
    while (expq.size() != 0 && guard < 5000) begin
      @(negedge clock);
      guard++;
      if (expq.size() != 0) begin
        chk("busy_in_frame", busy[s], 1'b1);
        if (tail_of[s] != 0 && !(out_valid[s] && out_last[s]))
          chk("tail_in_ready", in_ready[s], 1'b0);
      end
    end
    chk("frame_drained", expq.size(), 0);
    chk("symbol_count", sym_count, frame_bits.size() + tail_of[s] * (k_of[s] - 1));
    @(posedge clock);
    #1;
    @(negedge clock);
    chk("idle_busy", busy[s], 1'b0);
    chk("idle_valid", out_valid[s], 1'b0);
    chk("idle_in_ready", in_ready[s], 1'b1);
    @(posedge clock);
    #1;
  endtask

  task automatic random_frame(input int len);
    frame_bits.delete();
    for (int i = 0; i < len; i++) frame_bits.push_back(1'($urandom));
  endtask

  initial begin : watchdog
    #900000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence of scenarios.
  initial begin
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid[i] = 1'b0;
      in_bit[i]   = 1'b0;
      in_last[i]  = 1'b0;
    end
    repeat (2) @(posedge clock);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("reset_out_valid", out_valid[i], 1'b0);
      chk("reset_out_last", out_last[i], 1'b0);
      chk("reset_out_sym", out_sym[i], 2'b00);
      chk("reset_in_ready", in_ready[i], 1'b1);
      chk("reset_busy", busy[i], 1'b0);
    end
    reset = 1'b0;
    @(posedge clock);
    #1;

    // K=3 frame 1,0,1,1 with free-flowing output, then with 1010 stalls.
    frame_bits = '{1'b1, 1'b0, 1'b1, 1'b1};
    rmode = 0;
    send_frame(0, 1'b0);
    drain(0);
    rmode = 1;
    send_frame(0, 1'b0);
    drain(0);

    // No-tail instance: two frames, each starting from the zero state.
    rmode = 0;
    frame_bits = '{1'b1, 1'b1};
    send_frame(1, 1'b0);
    drain(1);
    frame_bits = '{1'b1};
    send_frame(1, 1'b0);
    drain(1);

    // Reset one cycle into the tail: everything in flight is discarded.
    frame_bits = '{1'b1, 1'b0, 1'b1, 1'b1};
    send_frame(0, 1'b0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    chk("abort_out_valid", out_valid[0], 1'b0);
    chk("abort_out_last", out_last[0], 1'b0);
    chk("abort_busy", busy[0], 1'b0);
    chk("abort_in_ready", in_ready[0], 1'b1);
    expq.delete();
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock);
    #1;
    frame_bits = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    send_frame(0, 1'b0);
    drain(0);

    // K=7 long random frames with random stalls and input gaps.
    rmode = 2;
    for (int f = 0; f < 2; f++) begin
      random_frame(1000);
      send_frame(2, 1'b1);
      drain(2);
    end
    random_frame($urandom_range(1, 40));
    send_frame(2, 1'b1);
    drain(2);

    // Short random frames on both K=3 instances.
    for (int f = 0; f < 4; f++) begin
      random_frame($urandom_range(1, 20));
      send_frame(0, 1'b1);
      drain(0);
      random_frame($urandom_range(1, 20));
      send_frame(1, 1'b1);
      drain(1);
    end

    // Single-bit frame on K=3 with tail.
    rmode = 0;
    frame_bits = '{1'b1};
    send_frame(0, 1'b0);
    drain(0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
